single_cycle_riscv_core: RTL and testbench
==========================================

Name: single_cycle_riscv_core

Overview:
Single-cycle RV32I-subset processor core. Each instruction executes in one clock cycle.
- Instruction and data memories sit outside the core.
- The core drives PC to the instruction memory and receives instr combinationally.
- The core drives ALUResult/WriteData/MemWrite to the data memory and receives ReadData combinationally.
- The data memory writes on the rising edge of clk.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock; all state updates on rising edge
system_rstn  in  1  reset; asynchronous, active-high (1 = reset)
instr  in  32  instruction at PC (combinational from instruction memory)
ReadData  in  32  data-memory read word at ALUResult (combinational)
PC  out  32  current program counter (registered)
MemWrite  out  1  data-memory write enable (combinational)
ALUResult  out  32  ALU output; also the data-memory address
WriteData  out  32  rs2 register value; data-memory write data

Behaviour:
- Reset asserted: PC=RESET_PC immediately. x1..x31 are cleared to 0. MemWrite is forced 0 and register writes are suppressed.
- After reset deasserts, PC updates every rising edge to PCNext.
  - PCNext = PC+ImmExt if (beq and rs1==rs2) or jal.
  - Otherwise PCNext = PC+4.
  - Addition wraps mod 2^32.
- Register file:
  - 32x32; x0 always reads 0 and writes to it are ignored.
  - Two combinational read ports (rs1=instr[19:15], rs2=instr[24:20]).
  - One write port, rd=instr[11:7], written on the rising edge when RegWrite=1.
- Decode is by opcode. Immediates are sign-extended to 32 bits.
  - lw 0000011: I-imm; ALUResult=rs1+imm; rd<=ReadData.
  - sw 0100011: S-imm {instr[31:25],instr[11:7]}; ALUResult=rs1+imm; MemWrite=1; WriteData=rs2.
  - R-type 0110011: funct3/funct7[5] select add(000/0), sub(000/1), slt(010), or(110), and(111); rd<=result.
  - I-ALU 0010011: addi(000), slti(010), ori(110), andi(111); rd<=result.
  - beq 1100011: B-imm {instr[31],instr[7],instr[30:25],instr[11:8],0}; ALU computes rs1-rs2; branch taken when Zero.
  - jal 1101111: J-imm {instr[31],instr[19:12],instr[20],instr[30:21],0}; rd<=PC+4.
- slt/slti compare signed, result is 32'd1 or 32'd0. Overflow in add/sub is ignored (wraps).
- Result mux: ALU result (R/I-ALU), ReadData (lw), PC+4 (jal).
- Any unsupported opcode or funct executes as a NOP: no register write, MemWrite=0, PC+4.
- MemWrite is asserted only while a sw is the current instruction. ALUResult and WriteData are always driven, even when MemWrite=0.
- Reset during execution aborts the current instruction; its pending register write is not performed.
- A self-branch (beq x,x,0) keeps PC constant indefinitely.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL.
  - 3-bit ALU control enum: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - Immediate-type enum: I, S, B, J.
  - Result-source enum: ALU, MEM, PC4.
- One sub-module: riscv_controller.
  - Produces RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump and ALUControl from opcode, funct3 and funct7[5].
  - Datapath (PC register, register file, immediate extender, ALU, muxes) stays in the top.

Test Plan:
1. Reset: hold system_rstn=1 across 2 clocks -> PC=0, MemWrite=0. Release -> PC steps 0,4,8,C on successive edges.
2. addi x2,x0,5 (00500113); addi x3,x0,12; add x4,x2,x3; sw x4,84(x0) -> on the sw cycle MemWrite=1, ALUResult=84, WriteData=17.
3. Arithmetic/logic with x2=5, x3=12. Each result is stored via sw and checked on WriteData:
   - sub=7 (x3-x2)
   - or=13
   - and=4
   - slt x3<x2 = 0
   - slti x2<7 = 1
   - addi x0,x0,9 followed by a store of x0 -> 0
4. Data memory word at 96 preloaded 32'hDEADBEEF; lw x5,96(x0); sw x5,100(x0) -> MemWrite=1, ALUResult=100, WriteData=DEADBEEF.
5. Branch and jump:
   - beq x2,x3,+8 with x2!=x3 -> PC+4.
   - beq x2,x2,+8 -> PC+8.
   - jal x3,+8 at PC=0x10 -> next PC=0x18; a following sw of x3 shows WriteData=0x14.
6. Full regression program ends with sw of 25 to address 100, then beq x2,x2,0 (00210063):
   - every MemWrite shows address 96 or (100, data 25);
   - PC then stays fixed;
   - MemWrite stays 0 thereafter.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared decode constants, control enums and the immediate extender for the single-cycle RV32I core.
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} res_src_t;

    // Opcode bits are never part of an immediate, so only instr[31:7] is taken.
    function automatic logic [31:0] imm_ext(input logic [31:7] ins, input imm_src_t src);
        case (src)
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/riscv_controller.sv
// Main decoder: opcode/funct3/funct7[5] to datapath controls, purely combinational.
// Unsupported encodings decode to all-zero controls, which executes as a NOP.
module riscv_controller
    import riscv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic       o_reg_write,
    output logic [1:0] o_imm_src,
    output logic       o_alu_src,
    output logic       o_mem_write,
    output logic [1:0] o_result_src,
    output logic       o_branch,
    output logic       o_jump,
    output logic [2:0] o_alu_ctrl
);

    always_comb begin
        o_reg_write  = 1'b0;
        o_imm_src    = IMM_I;
        o_alu_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_result_src = RES_ALU;
        o_branch     = 1'b0;
        o_jump       = 1'b0;
        o_alu_ctrl   = ALU_ADD;
        case (i_opcode)
            OP_LW: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_result_src = RES_MEM;
            end
            OP_SW: begin
                o_imm_src   = IMM_S;
                o_alu_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            OP_R, OP_IALU: begin
                o_alu_src = (i_opcode == OP_IALU);
                case (i_funct3)
                    3'b000: begin
                        o_reg_write = 1'b1;
                        // funct7[5] only distinguishes sub for register operands; addi ignores it
                        o_alu_ctrl  = (i_opcode == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    end
                    3'b010: begin o_reg_write = 1'b1; o_alu_ctrl = ALU_SLT; end
                    3'b110: begin o_reg_write = 1'b1; o_alu_ctrl = ALU_OR;  end
                    3'b111: begin o_reg_write = 1'b1; o_alu_ctrl = ALU_AND; end
                    default: o_reg_write = 1'b0;
                endcase
            end
            OP_BEQ: begin
                if (i_funct3 == 3'b000) begin
                    o_branch   = 1'b1;
                    o_imm_src  = IMM_B;
                    o_alu_ctrl = ALU_SUB;
                end
            end
            OP_JAL: begin
                o_reg_write  = 1'b1;
                o_imm_src    = IMM_J;
                o_result_src = RES_PC4;
                o_jump       = 1'b1;
            end
            default: o_reg_write = 1'b0;
        endcase
    end

endmodule

// File: rtl/single_cycle_riscv_core.sv
// Single-cycle RV32I subset core: PC, register file, immediate extender, ALU and result muxes.
// Every instruction completes in one clk; memories are external and combinational on read.
module single_cycle_riscv_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        system_rstn,
    input  logic [31:0] instr,
    input  logic [31:0] ReadData,
    output logic [31:0] PC,
    output logic        MemWrite,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData
);

    logic [31:0] r_regs [1:31];
    logic [31:0] r_pc;

    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rd1, w_rd2, w_imm_ext, w_src_b, w_alu_result, w_result;
    logic [31:0] w_pc_plus4, w_pc_target, w_pc_next;
    logic        w_reg_write, w_alu_src, w_mem_write, w_branch, w_jump, w_zero;
    logic [1:0]  w_imm_src, w_result_src;
    logic [2:0]  w_alu_ctrl;

    riscv_controller u_ctrl (
        .i_opcode     (instr[6:0]),
        .i_funct3     (instr[14:12]),
        .i_funct7b5   (instr[30]),
        .o_reg_write  (w_reg_write),
        .o_imm_src    (w_imm_src),
        .o_alu_src    (w_alu_src),
        .o_mem_write  (w_mem_write),
        .o_result_src (w_result_src),
        .o_branch     (w_branch),
        .o_jump       (w_jump),
        .o_alu_ctrl   (w_alu_ctrl)
    );

    assign w_rs1 = instr[19:15];
    assign w_rs2 = instr[24:20];
    assign w_rd  = instr[11:7];

    assign w_rd1     = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rd2     = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_imm_ext = imm_ext(instr[31:7], imm_src_t'(w_imm_src));
    assign w_src_b   = w_alu_src ? w_imm_ext : w_rd2;

    always_comb begin
        case (w_alu_ctrl)
            ALU_SUB: w_alu_result = w_rd1 - w_src_b;
            ALU_AND: w_alu_result = w_rd1 & w_src_b;
            ALU_OR:  w_alu_result = w_rd1 | w_src_b;
            ALU_SLT: w_alu_result = {31'd0, $signed(w_rd1) < $signed(w_src_b)};
            default: w_alu_result = w_rd1 + w_src_b;
        endcase
    end

    assign w_zero      = (w_alu_result == 32'd0);
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_target = r_pc + w_imm_ext;
    assign w_pc_next   = ((w_branch && w_zero) || w_jump) ? w_pc_target : w_pc_plus4;

    always_comb begin
        case (w_result_src)
            RES_MEM: w_result = ReadData;
            RES_PC4: w_result = w_pc_plus4;
            default: w_result = w_alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge system_rstn) begin
        if (system_rstn) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // x0 has no storage; writes to it fall out of the rd != 0 guard
    always_ff @(posedge clk or posedge system_rstn) begin
        if (system_rstn) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_reg_write && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_result;
        end
    end

    assign PC        = r_pc;
    assign MemWrite  = w_mem_write & ~system_rstn;
    assign ALUResult = w_alu_result;
    assign WriteData = w_rd2;

endmodule

// File: tb/tb_single_cycle_riscv_core.sv
// Bench for single_cycle_riscv_core: ISA-level reference model plus directed programs with literal expectations.
module tb_single_cycle_riscv_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr, ReadData, PC, ALUResult, WriteData;
    logic        MemWrite;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    logic [31:0] mreg [32];
    logic [31:0] mmem [64];
    logic [31:0] mpc;
    logic [31:0] pcs [$];
    logic [63:0] stores [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instr    = imem[PC[7:2]];
    assign ReadData = dmem[ALUResult[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
            dmem[24] <= 32'hDEADBEEF;
        end else if (MemWrite) begin
            dmem[ALUResult[7:2]] <= WriteData;
        end
    end

    single_cycle_riscv_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .system_rstn (rst),
        .instr       (instr),
        .ReadData    (ReadData),
        .PC          (PC),
        .MemWrite    (MemWrite),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] f_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] f_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] f_b(int imm, int rs2, int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] f_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    // Compare DUT against the architectural model for the current instruction, then retire it in the model.
    task automatic step_check();
        logic [31:0] ins, a, b, ealu, nxt, wv;
        logic [31:0] immi, imms, immb, immj;
        logic        emw, we, chk_alu;
        logic [2:0]  f3;
        if (rst) begin
            chk("rst_pc", PC, 32'h0);
            chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
            mpc = 32'h0;
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
            for (int i = 0; i < 64; i++) mmem[i] = 32'd0;
            mmem[24] = 32'hDEADBEEF;
            return;
        end
        ins  = imem[mpc[7:2]];
        f3   = ins[14:12];
        a    = mreg[ins[19:15]];
        b    = mreg[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = mpc + 32'd4;
        emw = 1'b0; we = 1'b0; chk_alu = 1'b0; ealu = 32'd0; wv = 32'd0;
        case (ins[6:0])
            7'b0000011: begin ealu = a + immi; chk_alu = 1'b1; wv = mmem[ealu[7:2]]; we = 1'b1; end
            7'b0100011: begin ealu = a + imms; chk_alu = 1'b1; emw = 1'b1; end
            7'b0110011, 7'b0010011: begin
                logic [31:0] bb;
                bb = (ins[6:0] == 7'b0010011) ? immi : b;
                we = 1'b1; chk_alu = 1'b1;
                case (f3)
                    3'b000: ealu = (ins[6:0] == 7'b0110011 && ins[30]) ? a - bb : a + bb;
                    3'b010: ealu = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
                    3'b110: ealu = a | bb;
                    3'b111: ealu = a & bb;
                    default: begin we = 1'b0; chk_alu = 1'b0; end
                endcase
                wv = ealu;
            end
            7'b1100011: if (f3 == 3'b000 && a == b) nxt = mpc + immb;
            7'b1101111: begin nxt = mpc + immj; wv = mpc + 32'd4; we = 1'b1; end
            default: ;
        endcase
        chk("pc", PC, mpc);
        chk("memwrite", {31'd0, MemWrite}, {31'd0, emw});
        chk("writedata", WriteData, b);
        if (chk_alu) chk("aluresult", ALUResult, ealu);
        pcs.push_back(PC);
        if (MemWrite) stores.push_back({ALUResult, WriteData});
        if (we && ins[11:7] != 5'd0) mreg[ins[11:7]] = wv;
        if (emw) mmem[ealu[7:2]] = b;
        mpc = nxt;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        step_check();
    endtask

    task automatic run(input int ncyc);
        pcs.delete();
        stores.delete();
        rst = 1'b1;
        #1;
        chk("async_rst_pc", PC, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        step_check();
        repeat (ncyc) tick();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    endtask

    function automatic logic [31:0] pc_at(int i);
        return (i >= 0 && i < pcs.size()) ? pcs[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [63:0] st_at(int i);
        return (i < stores.size()) ? stores[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic chk_store(input string name, input int i, input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] s;
        s = st_at(i);
        chk({name, "_addr"}, s[63:32], addr);
        chk({name, "_data"}, s[31:0], data);
    endtask

    initial begin
        #1;
        // Reset and sequential fetch over NOPs
        clear_imem();
        run(6);
        chk("pc_seq0", pc_at(0), 32'h0);
        chk("pc_seq1", pc_at(1), 32'h4);
        chk("pc_seq2", pc_at(2), 32'h8);
        chk("pc_seq3", pc_at(3), 32'hC);

        // addi/add then store the sum
        clear_imem();
        imem[0] = 32'h0050_0113;
        imem[1] = f_i(12, 0, 0, 3, 7'h13);
        imem[2] = f_r(0, 3, 2, 0, 4);
        imem[3] = f_s(84, 4, 0);
        imem[4] = f_b(0, 0, 0);
        run(8);
        chk("t2_nstores", stores.size(), 32'd1);
        chk_store("t2_sw", 0, 32'd84, 32'd17);

        // ALU ops, each result stored
        clear_imem();
        imem[0]  = f_i(5, 0, 0, 2, 7'h13);
        imem[1]  = f_i(12, 0, 0, 3, 7'h13);
        imem[2]  = f_r(7'h20, 2, 3, 0, 4);
        imem[3]  = f_s(0, 4, 0);
        imem[4]  = f_r(0, 3, 2, 6, 4);
        imem[5]  = f_s(4, 4, 0);
        imem[6]  = f_r(0, 3, 2, 7, 4);
        imem[7]  = f_s(8, 4, 0);
        imem[8]  = f_r(0, 2, 3, 2, 4);
        imem[9]  = f_s(12, 4, 0);
        imem[10] = f_i(7, 2, 2, 4, 7'h13);
        imem[11] = f_s(16, 4, 0);
        imem[12] = f_i(9, 0, 0, 0, 7'h13);
        imem[13] = f_s(20, 0, 0);
        imem[14] = f_b(0, 0, 0);
        run(18);
        chk("t3_nstores", stores.size(), 32'd6);
        chk_store("t3_sub", 0, 32'd0, 32'd7);
        chk_store("t3_or", 1, 32'd4, 32'd13);
        chk_store("t3_and", 2, 32'd8, 32'd4);
        chk_store("t3_slt", 3, 32'd12, 32'd0);
        chk_store("t3_slti", 4, 32'd16, 32'd1);
        chk_store("t3_x0", 5, 32'd20, 32'd0);

        // Load from preloaded word, store it back; x4 must have been cleared by reset
        clear_imem();
        imem[0] = f_i(96, 0, 2, 5, 7'h03);
        imem[1] = f_s(100, 5, 0);
        imem[2] = f_s(104, 4, 0);
        imem[3] = f_b(0, 0, 0);
        run(6);
        chk("t4_nstores", stores.size(), 32'd2);
        chk_store("t4_lw", 0, 32'd100, 32'hDEADBEEF);
        chk_store("t4_clr", 1, 32'd104, 32'd0);

        // Branches and jal
        clear_imem();
        imem[0] = f_i(5, 0, 0, 2, 7'h13);
        imem[1] = f_b(8, 3, 2);
        imem[2] = f_b(8, 2, 2);
        imem[3] = f_i(1, 0, 0, 7, 7'h13);
        imem[4] = f_j(8, 3);
        imem[5] = f_i(2, 0, 0, 7, 7'h13);
        imem[6] = f_s(0, 3, 0);
        imem[7] = f_b(0, 0, 0);
        run(8);
        chk("t5_pc1", pc_at(1), 32'h4);
        chk("t5_pc2", pc_at(2), 32'h8);
        chk("t5_pc3", pc_at(3), 32'h10);
        chk("t5_pc4", pc_at(4), 32'h18);
        chk("t5_pc5", pc_at(5), 32'h1C);
        chk("t5_nstores", stores.size(), 32'd1);
        chk_store("t5_jal_link", 0, 32'd0, 32'h14);

        // Regression program ending in a self-branch; store during reset must be masked
        clear_imem();
        imem[0] = f_s(96, 0, 0);
        imem[1] = f_i(5, 0, 0, 2, 7'h13);
        imem[2] = f_i(12, 0, 0, 3, 7'h13);
        imem[3] = f_r(0, 3, 2, 0, 6);
        imem[4] = f_i(8, 6, 0, 6, 7'h13);
        imem[5] = f_s(100, 6, 0);
        imem[6] = 32'h0021_0063;
        run(20);
        chk("t6_nstores", stores.size(), 32'd2);
        chk_store("t6_sw96", 0, 32'd96, 32'd0);
        chk_store("t6_sw100", 1, 32'd100, 32'd25);
        chk("t6_pc_hold_a", pc_at(pcs.size() - 12), 32'h18);
        chk("t6_pc_hold_b", pc_at(pcs.size() - 1), 32'h18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
